// File: rtl/tiny_dnn_core_mc.sv
// tiny_dnn_core_mc: multi-channel bfloat16 dot-product core.
// N_CH weight banks share one broadcast operand stream. Each bank has its own
// FMA accumulator. After fin, every accumulator is normalised to fp32 and the
// results are streamed out one channel at a time on a valid/ready interface.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i_write/i_read/i_ch_sel/i_a weight bank write (IDLE only) / read access
//   i_d                         bf16 write data or exec operand
//   i_init/i_exec/i_fin         clear / multiply-accumulate / end of vector
//   o_busy, o_w                 busy flag, registered read data
//   o_out_*/i_out_ready         result stream (data, channel, last)
module tiny_dnn_core_mc #(
    parameter  int unsigned N_CH   = 4,
    parameter  int unsigned F_SIZE = 512,
    localparam int unsigned AW     = $clog2(F_SIZE),
    localparam int unsigned CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_write,
    input  logic          i_read,
    input  logic          i_init,
    input  logic          i_exec,
    input  logic          i_fin,
    input  logic [AW-1:0] i_a,
    input  logic [CW-1:0] i_ch_sel,
    input  logic [15:0]   i_d,
    output logic          o_busy,
    output logic [15:0]   o_w,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [31:0]   o_out_data,
    output logic [CW-1:0] o_out_ch,
    output logic          o_out_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACC, S_DRAIN1, S_DRAIN2, S_NORM, S_OUT
    } state_t;

    state_t r_state, w_nstate;

    logic [15:0]        r_mem [N_CH][F_SIZE];
    logic               r_ex_v, r_m_v, w_ex_acc;
    logic [AW-1:0]      r_ex_a;
    logic [15:0]        r_ex_d, r_m_d;
    logic [15:0]        r_m_w [N_CH];
    logic               r_sign [N_CH], w_sign [N_CH];
    logic signed [9:0]  r_expo [N_CH], w_expo [N_CH];
    logic signed [31:0] r_addo [N_CH], w_addo [N_CH];
    logic [31:0]        r_res  [N_CH], w_res  [N_CH];
    logic               r_busy, w_busy;
    logic [15:0]        r_w;
    logic               r_out_valid, w_out_valid, r_out_last, w_out_last;
    logic [31:0]        r_out_data, w_out_data;
    logic [CW-1:0]      r_out_ch, w_out_ch, w_nxt_ch;

    // One FMA step: returns {sign, expo, addo}; unchanged when the product is dropped.
    function automatic logic [42:0] f_fma(input logic s, input logic signed [9:0] eo,
                                          input logic signed [31:0] ao,
                                          input logic [15:0] wv, input logic [15:0] dv);
        logic [15:0]        frac;
        logic signed [9:0]  expm;
        logic signed [11:0] expd;
        logic signed [31:0] addn;
        logic signed [48:0] alin;
        logic               keep;
        frac = 16'({1'b1, wv[6:0]}) * 16'({1'b1, dv[6:0]});
        expm = 10'(wv[14:7]) + 10'(dv[14:7]);
        expd = 12'(expm) - 12'(eo) + 12'sd16;
        // Accumulator is stored relative to its sign; re-express it in the product's sign.
        addn = (s ^ wv[15] ^ dv[15]) ? -ao : ao;
        alin = {addn[31], addn, 16'h0};
        if (expd < 12'sd0 || expd > 12'sd63) alin = '0;
        else                                 alin = alin >>> expd[5:0];
        // Product is dropped on a zero operand, a negative shift or an aligned overflow.
        keep = (wv[14:7] != 8'h0) && (dv[14:7] != 8'h0) && (expd >= 12'sd0) &&
               ((&alin[48:30]) || !(|alin[48:30]));
        if (keep) f_fma = {wv[15] ^ dv[15], expm, 32'(frac) + alin[31:0]};
        else      f_fma = {s, eo, ao};
    endfunction

    // Accumulator to fp32: truncating mantissa, flush to zero, saturate to infinity.
    function automatic logic [31:0] f_norm(input logic s, input logic signed [9:0] eo,
                                           input logic signed [31:0] ao);
        logic [31:0]        mag;
        logic               sn;
        logic [5:0]         lz;
        logic signed [11:0] expn;
        mag = ao[31] ? -ao : ao;
        sn  = s ^ ao[31];
        lz  = 6'd32;
        for (int i = 0; i < 32; i++) if (mag[i]) lz = 6'(31 - i);
        expn = 12'(eo) - $signed({6'b0, lz}) + 12'sd17 - 12'sd127;
        if (mag == 32'h0 || expn <= 12'sd0) f_norm = 32'h0;
        else if (expn >= 12'sd255)          f_norm = {sn, 8'hFF, 23'h0};
        else                                f_norm = {sn, expn[7:0], 23'((mag << lz) >> 8)};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    // Next state, accumulator updates and next output values
    always_comb begin
        w_nstate    = r_state;
        w_sign      = r_sign;
        w_expo      = r_expo;
        w_addo      = r_addo;
        w_res       = r_res;
        w_out_valid = r_out_valid;
        w_out_data  = r_out_data;
        w_out_ch    = r_out_ch;
        w_out_last  = r_out_last;
        w_nxt_ch    = CW'(r_out_ch + 1'b1);
        w_ex_acc    = i_exec & ~i_init & ((r_state == S_IDLE) | (r_state == S_ACC));

        if (r_m_v) begin
            for (int c = 0; c < N_CH; c++)
                {w_sign[c], w_expo[c], w_addo[c]} = f_fma(r_sign[c], r_expo[c], r_addo[c],
                                                          r_m_w[c], r_m_d);
        end

        case (r_state)
            S_IDLE:   if (w_ex_acc) w_nstate = S_ACC;
            S_ACC:    if (i_fin) w_nstate = S_DRAIN1;
            S_DRAIN1: w_nstate = S_DRAIN2;
            S_DRAIN2: w_nstate = S_NORM;
            S_NORM: begin
                for (int c = 0; c < N_CH; c++) begin
                    w_res[c]  = f_norm(r_sign[c], r_expo[c], r_addo[c]);
                    w_sign[c] = 1'b0;
                    w_expo[c] = '0;
                    w_addo[c] = '0;
                end
                w_out_valid = 1'b1;
                w_out_ch    = '0;
                w_out_data  = w_res[0];
                w_out_last  = (N_CH == 1);
                w_nstate    = S_OUT;
            end
            S_OUT: begin
                if (r_out_valid && i_out_ready) begin
                    if (r_out_last) begin
                        w_out_valid = 1'b0;
                        w_out_last  = 1'b0;
                        w_out_ch    = '0;
                        w_out_data  = 32'h0;
                        w_nstate    = S_IDLE;
                    end else begin
                        w_out_ch   = w_nxt_ch;
                        w_out_data = r_res[w_nxt_ch];
                        w_out_last = (w_nxt_ch == CW'(N_CH - 1));
                    end
                end
            end
            default: w_nstate = S_IDLE;
        endcase

        if (i_init) begin
            w_nstate    = S_IDLE;
            w_out_valid = 1'b0;
            w_out_last  = 1'b0;
            w_out_ch    = '0;
            w_out_data  = 32'h0;
            for (int c = 0; c < N_CH; c++) begin
                w_sign[c] = 1'b0;
                w_expo[c] = '0;
                w_addo[c] = '0;
            end
        end

        w_busy = w_ex_acc | (r_ex_v & ~i_init) |
                 ~((w_nstate == S_IDLE) | (w_nstate == S_ACC));
    end

    // Control, accumulators and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v      <= 1'b0;
            r_m_v       <= 1'b0;
            r_busy      <= 1'b0;
            r_w         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_sign[c] <= 1'b0;
                r_expo[c] <= '0;
                r_addo[c] <= '0;
                r_res[c]  <= '0;
            end
        end else begin
            r_ex_v      <= w_ex_acc;
            r_m_v       <= r_ex_v & ~i_init;
            r_busy      <= w_busy;
            if (i_read) r_w <= r_mem[i_ch_sel][i_a];
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_out_ch    <= w_out_ch;
            r_out_last  <= w_out_last;
            r_sign      <= w_sign;
            r_expo      <= w_expo;
            r_addo      <= w_addo;
            r_res       <= w_res;
        end
    end

    // Weight RAM and exec datapath (no reset needed)
    always_ff @(posedge clk) begin
        if (i_write && r_state == S_IDLE) r_mem[i_ch_sel][i_a] <= i_d;
        if (w_ex_acc) begin
            r_ex_a <= i_a;
            r_ex_d <= i_d;
        end
        r_m_d <= r_ex_d;
        for (int c = 0; c < N_CH; c++) r_m_w[c] <= r_mem[c][r_ex_a];
    end

    assign o_busy      = r_busy;
    assign o_w         = r_w;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;
    assign o_out_last  = r_out_last;

endmodule
